// File: rtl/riscv_ex_wb_buffer.sv
// EX->WB result FIFO with DIFT tags, newest-first forwarding
// lookup for ID and a saturating tainted write-back counter.
module riscv_ex_wb_buffer #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 1,
    parameter int CNT_WIDTH  = 16,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic                  ex_we_i,
    input  logic [4:0]            ex_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    input  logic [TAG_WIDTH-1:0]  ex_wdata_tag_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [4:0]            wb_waddr_o,
    output logic [DATA_WIDTH-1:0] wb_wdata_o,
    output logic [TAG_WIDTH-1:0]  wb_wdata_tag_o,
    input  logic [4:0]            fw_raddr_i,
    output logic                  fw_hit_o,
    output logic [DATA_WIDTH-1:0] fw_wdata_o,
    output logic [TAG_WIDTH-1:0]  fw_tag_o,
    output logic [CW-1:0]         count_o,
    output logic [CNT_WIDTH-1:0]  taint_cnt_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [4:0]            r_waddr [DEPTH];
    logic [DATA_WIDTH-1:0] r_wdata [DEPTH];
    logic [TAG_WIDTH-1:0]  r_tag   [DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic [CNT_WIDTH-1:0]  r_taint;

    logic                  w_full;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [PW-1:0]         w_idx;
    logic                  w_fw_hit;
    logic [DATA_WIDTH-1:0] w_fw_wdata;
    logic [TAG_WIDTH-1:0]  w_fw_tag;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_full     = (r_count == FULL);
    assign ex_ready_o = !w_full || wb_ready_i;
    assign wb_valid_o = (r_count != '0);

    // Beats without a write-back are consumed but never stored
    assign w_accept = ex_valid_i && ex_ready_o;
    assign w_push   = w_accept && ex_we_i && !flush_i;
    assign w_pop    = wb_valid_o && wb_ready_i && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_waddr[i] <= '0;
                r_wdata[i] <= '0;
                r_tag[i]   <= '0;
            end
        end else if (w_push) begin
            r_waddr[r_wr_ptr] <= ex_waddr_i;
            r_wdata[r_wr_ptr] <= ex_wdata_i;
            r_tag[r_wr_ptr]   <= ex_wdata_tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_taint <= '0;
        else if (w_pop && (|r_tag[r_rd_ptr]) && (r_taint != '1))
            r_taint <= r_taint + CNT_WIDTH'(1);
    end

    // Walk oldest to newest so the newest match wins
    always_comb begin
        w_fw_hit   = 1'b0;
        w_fw_wdata = '0;
        w_fw_tag   = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = PW'((int'(r_rd_ptr) + i) % DEPTH);
            if ((i < int'(r_count)) && (fw_raddr_i != 5'd0) &&
                (r_waddr[w_idx] == fw_raddr_i)) begin
                w_fw_hit   = 1'b1;
                w_fw_wdata = r_wdata[w_idx];
                w_fw_tag   = r_tag[w_idx];
            end
        end
    end

    assign wb_waddr_o     = r_waddr[r_rd_ptr];
    assign wb_wdata_o     = r_wdata[r_rd_ptr];
    assign wb_wdata_tag_o = r_tag[r_rd_ptr];
    assign fw_hit_o       = w_fw_hit;
    assign fw_wdata_o     = w_fw_wdata;
    assign fw_tag_o       = w_fw_tag;
    assign count_o        = r_count;
    assign taint_cnt_o    = r_taint;

endmodule

// File: tb/tb_riscv_ex_wb_buffer.sv
// Scoreboard bench for riscv_ex_wb_buffer (DEPTH=2, CNT_WIDTH=2).
// Driver queues expected heads; a negedge monitor checks every pop.
module tb_riscv_ex_wb_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic        ex_we_i = 1'b0;
    logic [4:0]  ex_waddr_i = '0;
    logic [31:0] ex_wdata_i = '0;
    logic [0:0]  ex_wdata_tag_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic [0:0]  wb_wdata_tag_o;
    logic [4:0]  fw_raddr_i = '0;
    logic        fw_hit_o;
    logic [31:0] fw_wdata_o;
    logic [0:0]  fw_tag_o;
    logic [1:0]  count_o;
    logic [1:0]  taint_cnt_o;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [0:0]  t;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] taint_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    riscv_ex_wb_buffer #(
        .DEPTH(2), .DATA_WIDTH(32), .TAG_WIDTH(1), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i),
        .ex_wdata_i(ex_wdata_i), .ex_wdata_tag_i(ex_wdata_tag_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
        .wb_wdata_tag_o(wb_wdata_tag_o), .fw_raddr_i(fw_raddr_i),
        .fw_hit_o(fw_hit_o), .fw_wdata_o(fw_wdata_o),
        .fw_tag_o(fw_tag_o), .count_o(count_o),
        .taint_cnt_o(taint_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every head that WB consumes must match the queue front
    always @(negedge clk) begin
        if (rst_n && !flush_i && wb_valid_o && wb_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop actual=%0h required=none",
                         wb_waddr_o);
            end else begin
                m_e = sb.pop_front();
                chk("wb_waddr", 32'(wb_waddr_o), 32'(m_e.a));
                chk("wb_wdata", wb_wdata_o, m_e.d);
                chk("wb_tag", 32'(wb_wdata_tag_o), 32'(m_e.t));
            end
        end
    end

    task automatic send(input logic [4:0] a, input logic [31:0] d,
                        input logic t, input logic we);
        int n = 0;
        ex_valid_i = 1'b1;
        ex_we_i = we;
        ex_waddr_i = a;
        ex_wdata_i = d;
        ex_wdata_tag_i = t;
        @(negedge clk);
        while (!ex_ready_o && n < 10) begin
            n++;
            @(negedge clk);
        end
        if (!ex_ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=0 required=1");
        end else if (we) begin
            sb.push_back('{a, d, t});
        end
        @(posedge clk);
        #1;
        ex_valid_i = 1'b0;
        ex_we_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_valid", 32'(wb_valid_o), 0);
        chk("rst_hit", 32'(fw_hit_o), 0);
        chk("rst_taint", 32'(taint_cnt_o), 0);
        chk("rst_ready", 32'(ex_ready_o), 1);
        chk("rst_wdata", wb_wdata_o, 0);
        chk("rst_fwdata", fw_wdata_o, 0);

        // Streaming with WB always ready
        @(posedge clk);
        #1;
        wb_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ex_valid_i = 1'b1;
            ex_we_i = 1'b1;
            ex_waddr_i = 5'(i + 1);
            ex_wdata_i = 32'((i + 1) * 16);
            ex_wdata_tag_i = 1'b0;
            @(negedge clk);
            chk("stream_ready", 32'(ex_ready_o), 1);
            chk("stream_count", 32'(count_o), (i == 0) ? 0 : 1);
            sb.push_back('{5'(i + 1), 32'((i + 1) * 16), 1'b0});
            @(posedge clk);
            #1;
        end
        ex_valid_i = 1'b0;
        ex_we_i = 1'b0;
        @(negedge clk);
        chk("stream_tail_count", 32'(count_o), 1);
        @(negedge clk);
        chk("stream_empty", 32'(count_o), 0);

        // Full and stall, then pop+push in one cycle
        @(posedge clk);
        #1;
        wb_ready_i = 1'b0;
        send(5'd1, 32'h100, 1'b0, 1'b1);
        send(5'd2, 32'h200, 1'b0, 1'b1);
        ex_valid_i = 1'b1;
        ex_we_i = 1'b1;
        ex_waddr_i = 5'd3;
        ex_wdata_i = 32'h300;
        ex_wdata_tag_i = 1'b0;
        @(negedge clk);
        chk("full_ready", 32'(ex_ready_o), 0);
        chk("full_count", 32'(count_o), 2);
        chk("full_head", 32'(wb_waddr_o), 1);
        @(posedge clk);
        #1;
        wb_ready_i = 1'b1;
        @(negedge clk);
        chk("full_pop_ready", 32'(ex_ready_o), 1);
        chk("full_pop_count", 32'(count_o), 2);
        sb.push_back('{5'd3, 32'h300, 1'b0});
        @(posedge clk);
        #1;
        ex_valid_i = 1'b0;
        ex_we_i = 1'b0;
        wb_ready_i = 1'b0;
        @(negedge clk);
        chk("full_after_count", 32'(count_o), 2);
        chk("full_after_head", 32'(wb_waddr_o), 2);
        @(posedge clk);
        #1;
        wb_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        wb_ready_i = 1'b0;
        @(negedge clk);
        chk("full_drained", 32'(count_o), 0);

        // Forwarding priority and visibility
        @(posedge clk);
        #1;
        fw_raddr_i = 5'd5;
        ex_valid_i = 1'b1;
        ex_we_i = 1'b1;
        ex_waddr_i = 5'd5;
        ex_wdata_i = 32'hA;
        ex_wdata_tag_i = 1'b0;
        @(negedge clk);
        chk("fw_push_invisible", 32'(fw_hit_o), 0);
        sb.push_back('{5'd5, 32'hA, 1'b0});
        @(posedge clk);
        #1;
        send(5'd5, 32'hB, 1'b1, 1'b1);
        @(negedge clk);
        chk("fw_hit", 32'(fw_hit_o), 1);
        chk("fw_newest_data", fw_wdata_o, 32'hB);
        chk("fw_newest_tag", 32'(fw_tag_o), 1);
        fw_raddr_i = 5'd0;
        #1;
        chk("fw_r0_miss", 32'(fw_hit_o), 0);
        chk("fw_r0_data", fw_wdata_o, 0);
        fw_raddr_i = 5'd7;
        #1;
        chk("fw_r7_miss", 32'(fw_hit_o), 0);
        fw_raddr_i = 5'd5;
        @(posedge clk);
        #1;
        wb_ready_i = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        wb_ready_i = 1'b0;
        @(negedge clk);
        chk("fw_one_left_count", 32'(count_o), 1);
        chk("fw_one_left_data", fw_wdata_o, 32'hB);
        @(posedge clk);
        #1;
        wb_ready_i = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        wb_ready_i = 1'b0;
        @(negedge clk);
        chk("fw_gone_hit", 32'(fw_hit_o), 0);
        chk("fw_gone_data", fw_wdata_o, 0);
        chk("fw_taint", 32'(taint_cnt_o), 1);

        // Beat without write-back is consumed and dropped
        @(posedge clk);
        #1;
        send(5'd9, 32'h99, 1'b0, 1'b0);
        @(negedge clk);
        chk("we0_count", 32'(count_o), 0);
        chk("we0_valid", 32'(wb_valid_o), 0);

        // Flush colliding with push and pop
        @(posedge clk);
        #1;
        send(5'd1, 32'h111, 1'b1, 1'b1);
        send(5'd2, 32'h222, 1'b1, 1'b1);
        ex_valid_i = 1'b1;
        ex_we_i = 1'b1;
        ex_waddr_i = 5'd3;
        ex_wdata_i = 32'h333;
        ex_wdata_tag_i = 1'b1;
        wb_ready_i = 1'b1;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_pre_count", 32'(count_o), 2);
        chk("flush_pre_ready", 32'(ex_ready_o), 1);
        @(posedge clk);
        sb.delete();
        #1;
        flush_i = 1'b0;
        ex_valid_i = 1'b0;
        ex_we_i = 1'b0;
        wb_ready_i = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(count_o), 0);
        chk("flush_valid", 32'(wb_valid_o), 0);
        chk("flush_taint", 32'(taint_cnt_o), 1);
        @(posedge clk);
        #1;
        wb_ready_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("flush_no_ghost", 32'(wb_valid_o), 0);
        end

        // Clear the counter, then saturate it
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst2_taint", 32'(taint_cnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            send(5'(10 + i), 32'(i), 1'b1, 1'b1);
            @(posedge clk);
            #1;
            chk("taint_sat", 32'(taint_cnt_o), 32'(taint_exp[i]));
        end

        // Asynchronous reset with entries pending
        wb_ready_i = 1'b0;
        send(5'd20, 32'h2020, 1'b1, 1'b1);
        send(5'd21, 32'h2121, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_taint", 32'(taint_cnt_o), 0);
        chk("arst_valid", 32'(wb_valid_o), 0);
        chk("arst_count", 32'(count_o), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready", 32'(ex_ready_o), 1);
        chk("arst_hit", 32'(fw_hit_o), 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
